// File: rtl/evt_pkg.sv
// Shared FSM encodings and sizing helpers for the event stretcher.
package evt_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_HIGH = 2'd1;
    localparam logic [ST_W-1:0] ST_GAP  = 2'd2;

    // Counter holds at most max(high, gap) - 1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/evt_stretch_if.sv
// Event-in / stretched-pulse-out bundle between a source and the stretcher.
interface evt_stretch_if #(
    parameter int PEND_W = 3
);
    logic              evt_in;
    logic              ovf_clr;
    logic              sig1;
    logic [PEND_W-1:0] pend_cnt;
    logic              busy;
    logic              ovf;

    modport master (
        output evt_in, ovf_clr,
        input  sig1, pend_cnt, busy, ovf
    );

    modport slave (
        input  evt_in, ovf_clr,
        output sig1, pend_cnt, busy, ovf
    );
endinterface

// File: rtl/sat_updn_cnt.sv
// Up/down counter that holds at all-ones and at zero.
module sat_updn_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign sat_o = &cnt_q;
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !sat_o)
            cnt_d = cnt_q + 1'b1;
        else if (dec_i && !inc_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/evt_stretch.sv
// Stretches single-cycle events into fixed-width pulses with a minimum
// low gap, queueing events that arrive while a pulse is in flight.
module evt_stretch
    import evt_pkg::*;
#(
    parameter int HIGH_CYC = 4,
    parameter int GAP_CYC  = 4,
    parameter int PEND_W   = 3
) (
    input  logic         clk1,
    input  logic         rst,
    evt_stretch_if.slave bus
);
    localparam int CNT_W = cnt_width(HIGH_CYC, GAP_CYC);
    localparam logic [CNT_W-1:0] HI_LD = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] GP_LD = CNT_W'(GAP_CYC - 1);

    logic [ST_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sig1_q, ovf_q, ovf_d;
    logic [PEND_W-1:0] pend;
    logic              pend_sat, pend_nz, cnt_zero;
    logic              want, consume, inc, dec, drop;

    assign pend_nz  = |pend;
    assign cnt_zero = (cnt_q == '0);
    assign want     = bus.evt_in | pend_nz;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        consume = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (want) begin
                    consume = 1'b1;
                    state_d = ST_HIGH;
                    cnt_d   = HI_LD;
                end
            end
            ST_HIGH: begin
                if (cnt_zero) begin
                    state_d = ST_GAP;
                    cnt_d   = GP_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (want) begin
                    consume = 1'b1;
                    state_d = ST_HIGH;
                    cnt_d   = HI_LD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Queued events have priority; a live event is queued unless taken now.
    assign dec   = consume & pend_nz;
    assign inc   = bus.evt_in & ~(consume & ~pend_nz);
    assign drop  = inc & ~dec & pend_sat;
    assign ovf_d = drop | (ovf_q & ~bus.ovf_clr);

    sat_updn_cnt #(
        .W(PEND_W)
    ) u_pend (
        .clk   (clk1),
        .rst   (rst),
        .inc_i (inc),
        .dec_i (dec),
        .cnt_o (pend),
        .sat_o (pend_sat)
    );

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sig1_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig1_q  <= (state_d == ST_HIGH);
            ovf_q   <= ovf_d;
        end
    end

    assign bus.sig1     = sig1_q;
    assign bus.pend_cnt = pend;
    assign bus.busy     = (state_q != ST_IDLE) | pend_nz;
    assign bus.ovf      = ovf_q;
endmodule
